// File: rtl/lemming_world_pkg.sv
// Shared definitions for the lemming walker and its environment model:
// default terrain/timing parameters and the walker state encodings.
package lemming_pkg;

  localparam int W_DEFAULT           = 16;
  localparam int DIG_CYCLES_DEFAULT  = 4;
  localparam int FALL_CYCLES_DEFAULT = 3;

  typedef enum logic [2:0] {
    WALK_LEFT  = 3'd0,
    WALK_RIGHT = 3'd1,
    FALL_LEFT  = 3'd2,
    FALL_RIGHT = 3'd3,
    DIG_LEFT   = 3'd4,
    DIG_RIGHT  = 3'd5,
    SPLAT      = 3'd6
  } walker_state_e;

endpackage

// File: rtl/lemming_world_cycle_counter.sv
// Counts consecutive enabled cycles and pulses tc_o on the cycle that
// completes a run of LEN, wrapping back to zero. Clear has priority.
import lemming_pkg::*;

module lemming_cycle_counter #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic areset,
  input  logic enable_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = enable_i && !clear_i && (count_q == LAST);

  // Next count: clear wins, otherwise advance while enabled and wrap at the end of a run.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // Count register, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lemming_world.sv
// Environment model closing the loop around the lemming walker: holds the
// terrain and lemming column, moves/digs/fills from the walker outputs and
// presents registered (Moore) sensor outputs back to it.
import lemming_pkg::*;

module lemming_world #(
  parameter  int W           = W_DEFAULT,
  parameter  int DIG_CYCLES  = DIG_CYCLES_DEFAULT,
  parameter  int FALL_CYCLES = FALL_CYCLES_DEFAULT,
  localparam int PW          = $clog2(W)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          load,
  input  logic [PW-1:0] load_pos,
  input  logic [W-1:0]  load_holes,
  input  logic [W-1:0]  load_walls,
  input  logic          walk_left,
  input  logic          walk_right,
  input  logic          aaah,
  input  logic          digging,
  output logic          ground,
  output logic          bump_left,
  output logic          bump_right,
  output logic [PW-1:0] pos,
  output logic [W-1:0]  holes
);

  localparam logic [PW-1:0] LAST_COL = PW'(W - 1);

  logic [PW-1:0] pos_q, pos_d;
  logic [W-1:0]  holes_q, holes_d;
  logic [W-1:0]  walls_q, walls_d;

  logic digEnable, digClear, digDone;
  logic fallEnable, fallClear, fallDone;

  // Sensors depend only on registered state so the walker sees no combinational path.
  assign ground     = ~holes_q[pos_q];
  assign bump_left  = (pos_q == '0) || walls_q[pos_q - PW'(1)];
  assign bump_right = (pos_q == LAST_COL) || walls_q[pos_q];
  assign pos        = pos_q;
  assign holes      = holes_q;

  // Digging only counts while standing on ground; stopping the dig restarts the run.
  assign digEnable  = !load && digging && ground;
  assign digClear   = load || !digging;

  // Falling only counts while airborne; leaving the fall restarts the run.
  assign fallEnable = !load && aaah && !ground;
  assign fallClear  = load || !aaah;

  lemming_cycle_counter #(.LEN(DIG_CYCLES)) u_digCounter (
    .clk      (clk),
    .areset   (areset),
    .enable_i (digEnable),
    .clear_i  (digClear),
    .tc_o     (digDone)
  );

  lemming_cycle_counter #(.LEN(FALL_CYCLES)) u_fallCounter (
    .clk      (clk),
    .areset   (areset),
    .enable_i (fallEnable),
    .clear_i  (fallClear),
    .tc_o     (fallDone)
  );

  // Next terrain/position: a load replaces everything, otherwise move, dig and fill independently.
  always_comb begin
    pos_d   = pos_q;
    holes_d = holes_q;
    walls_d = walls_q;
    if (load) begin
      pos_d   = load_pos;
      holes_d = load_holes;
      walls_d = load_walls;
    end else begin
      if (walk_left && !walk_right && ground && !bump_left) begin
        pos_d = pos_q - PW'(1);
      end else if (walk_right && !walk_left && ground && !bump_right) begin
        pos_d = pos_q + PW'(1);
      end
      if (digDone) begin
        holes_d[pos_q] = 1'b1;
      end
      if (fallDone) begin
        holes_d[pos_q] = 1'b0;
      end
    end
  end

  // World state registers; reset leaves a flat, wall-free terrain with the lemming at column 0.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pos_q   <= '0;
      holes_q <= '0;
      walls_q <= '0;
    end else begin
      pos_q   <= pos_d;
      holes_q <= holes_d;
      walls_q <= walls_d;
    end
  end

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world with an 8-column world: a table of
// single-edge vectors plus hand-written asynchronous-reset sequences.
module tb_lemming_world;

  logic       clk = 1'b0;
  logic       areset;
  logic       load;
  logic [2:0] load_pos;
  logic [7:0] load_holes;
  logic [7:0] load_walls;
  logic       walk_left, walk_right, aaah, digging;
  logic       ground, bump_left, bump_right;
  logic [2:0] pos;
  logic [7:0] holes;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       ld;
    logic [2:0] ldPos;
    logic [7:0] ldHoles;
    logic [7:0] ldWalls;
    logic       wl, wr, aa, dg;
    logic [2:0] expPos;
    logic [7:0] expHoles;
    logic       expG, expBl, expBr;
  } vec_t;

  vec_t vecs[$];

  lemming_world #(.W(8), .DIG_CYCLES(4), .FALL_CYCLES(3)) dut (
    .clk        (clk),
    .areset     (areset),
    .load       (load),
    .load_pos   (load_pos),
    .load_holes (load_holes),
    .load_walls (load_walls),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .ground     (ground),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .pos        (pos),
    .holes      (holes)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic ld, logic [2:0] lp, logic [7:0] lh, logic [7:0] lw,
                              logic wl, logic wr, logic aa, logic dg,
                              logic [2:0] ep, logic [7:0] eh, logic eg, logic ebl, logic ebr);
    vec_t v;
    v.name = nm; v.ld = ld; v.ldPos = lp; v.ldHoles = lh; v.ldWalls = lw;
    v.wl = wl; v.wr = wr; v.aa = aa; v.dg = dg;
    v.expPos = ep; v.expHoles = eh; v.expG = eg; v.expBl = ebl; v.expBr = ebr;
    return v;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [2:0] lp, input logic [7:0] lh,
                               input logic [7:0] lw, input logic wl, input logic wr,
                               input logic aa, input logic dg);
    load = ld; load_pos = lp; load_holes = lh; load_walls = lw;
    walk_left = wl; walk_right = wr; aaah = aa; digging = dg;
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] ep, input logic [7:0] eh,
                             input logic eg, input logic ebl, input logic ebr);
    checks++;
    if ({pos, holes, ground, bump_left, bump_right} !== {ep, eh, eg, ebl, ebr}) begin
      errors++;
      $display("[TB] FAIL %s: got pos=%0d holes=%h ground=%b bl=%b br=%b, want pos=%0d holes=%h ground=%b bl=%b br=%b",
               nm, pos, holes, ground, bump_left, bump_right, ep, eh, eg, ebl, ebr);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name, ld, ldPos, ldHoles, ldWalls, wl, wr, aa, dg, expPos, expHoles, g, bl, br
    vecs.push_back(mk("load3",      1, 3, 8'h00, 8'h00, 0, 0, 0, 0, 3, 8'h00, 1, 0, 0));
    vecs.push_back(mk("wl1",        0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("wl2",        0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1, 0, 0));
    vecs.push_back(mk("wl3",        0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk("wl4_edge",   0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk("wl5_edge",   0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk("load3_wall", 1, 3, 8'h00, 8'h10, 0, 0, 0, 0, 3, 8'h00, 1, 0, 0));
    vecs.push_back(mk("wr1",        0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 4, 8'h00, 1, 0, 1));
    vecs.push_back(mk("wr2_wall",   0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 4, 8'h00, 1, 0, 1));
    vecs.push_back(mk("wr3_wall",   0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 4, 8'h00, 1, 0, 1));
    vecs.push_back(mk("both_hold",  0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 4, 8'h00, 1, 0, 1));
    vecs.push_back(mk("wl_off_wall",0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 3, 8'h00, 1, 0, 0));
    vecs.push_back(mk("load2",      1, 2, 8'h00, 8'h00, 0, 0, 0, 0, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("dig1",       0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("dig2",       0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("dig3",       0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("dig4_open",  0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("wr_airborne",0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fall1",      0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fall2",      0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fall3_floor",0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digA1",      0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digA2",      0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("dig_idle",   0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digB1",      0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digB2",      0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digB3",      0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("digB4_open", 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fallB1",     0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fallB2",     0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h04, 0, 0, 0));
    vecs.push_back(mk("fallB3",     0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2, 8'h00, 1, 0, 0));
    vecs.push_back(mk("load_walk",  1, 5, 8'h01, 8'h00, 1, 0, 0, 0, 5, 8'h01, 1, 0, 0));
    vecs.push_back(mk("wl_after",   0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 4, 8'h01, 1, 0, 0));
    vecs.push_back(mk("aaah_gnd",   0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 4, 8'h01, 1, 0, 0));
    vecs.push_back(mk("load6",      1, 6, 8'h00, 8'h00, 0, 0, 0, 0, 6, 8'h00, 1, 0, 0));
    vecs.push_back(mk("wr_to7",     0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 7, 8'h00, 1, 0, 1));
    vecs.push_back(mk("wr_edge7",   0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 7, 8'h00, 1, 0, 1));

    areset = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    #12;
    checkOutput("reset", 0, 8'h00, 1, 1, 0);
    areset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].ldPos, vecs[i].ldHoles, vecs[i].ldWalls,
                    vecs[i].wl, vecs[i].wr, vecs[i].aa, vecs[i].dg);
      stepEdge();
      checkOutput(vecs[i].name, vecs[i].expPos, vecs[i].expHoles, vecs[i].expG,
                  vecs[i].expBl, vecs[i].expBr);
    end

    // Reset part-way through a fall: terrain snaps back at once, no floor restore lingers.
    applyStimulus(1, 6, 8'h40, 8'h00, 0, 0, 0, 0);
    stepEdge();
    checkOutput("load_hole6", 6, 8'h40, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    stepEdge();
    stepEdge();
    checkOutput("fall_mid", 6, 8'h40, 0, 0, 0);
    #2 areset = 1'b1;
    #1 checkOutput("areset_fall", 0, 8'h00, 1, 1, 0);
    #1 areset = 1'b0;
    stepEdge();
    checkOutput("after_areset_fall", 0, 8'h00, 1, 1, 0);

    // Reset part-way through a dig with digging held across it: the run must restart.
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    stepEdge();
    stepEdge();
    stepEdge();
    checkOutput("dig_mid", 0, 8'h00, 1, 1, 0);
    #2 areset = 1'b1;
    #1 checkOutput("areset_dig", 0, 8'h00, 1, 1, 0);
    #1 areset = 1'b0;
    stepEdge();
    checkOutput("dig_restart1", 0, 8'h00, 1, 1, 0);
    stepEdge();
    stepEdge();
    checkOutput("dig_restart3", 0, 8'h00, 1, 1, 0);
    stepEdge();
    checkOutput("dig_restart4", 0, 8'h01, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lemming_world.md
# lemming_world

Cycle-accurate environment model that drives the sensor side of the lemming walker FSM: it consumes the walker's `walk_left`/`walk_right`/`aaah`/`digging` outputs and produces `ground`/`bump_left`/`bump_right`. It holds a 1-D terrain of `W` columns (holes, internal walls) and the lemming's column position. It moves the lemming, removes ground when the lemming digs, and restores ground when a fall reaches the hole floor. It closes the loop around the walker FSM in the system testbench and in the on-chip demo. All sensor outputs are Moore, driven from registered state only, so no combinational loop forms with the walker.

## Interface
- `W`, 16: number of terrain columns, ≥2.
- `DIG_CYCLES`, 4: consecutive grounded `digging` cycles needed to open a hole, ≥1.
- `FALL_CYCLES`, 3: consecutive airborne `aaah` cycles to reach a hole floor, ≥1.
- `PW`, $clog2(W): position width (derived).
---
- `clk` in 1: clock.
- `areset` in 1: reset, asynchronous, active-high.
- `load` in 1: synchronous terrain/position load strobe.
- `load_pos` in PW: start column, must be < W.
- `load_holes` in W: bit i=1 → column i has no ground.
- `load_walls` in W: bit i=1 → wall between column i and i+1; bit W-1 ignored.
- `walk_left`, `walk_right`, `aaah`, `digging` in 1 each: walker outputs.
- `ground` out 1: `~holes[pos]`.
- `bump_left` out 1: `pos==0 || walls[pos-1]`.
- `bump_right` out 1: `pos==W-1 || walls[pos]`.
- `pos` out PW: current column.
- `holes` out W: current hole map.

## Operation
- State: `pos`, `holes`, `walls`, `dig_cnt`, `fall_cnt`. Outputs are pure functions of state.
- Priority per edge: `areset` > `load` > normal update.
- `load`: pos←load_pos, holes←load_holes, walls←load_walls, dig_cnt←0, fall_cnt←0. Walker inputs are ignored that cycle.
- Move:
  - `walk_left & ~walk_right & ground & ~bump_left` → pos−1.
  - `walk_right & ~walk_left & ground & ~bump_right` → pos+1.
  - Both asserted, or blocked → hold. Position never wraps.
- Dig:
  - `digging & ground` → dig_cnt+1.
  - When dig_cnt==DIG_CYCLES−1: holes[pos]←1 and dig_cnt←0.
  - `~digging` → dig_cnt←0.
- Fall:
  - `aaah & ~ground` → fall_cnt+1.
  - When fall_cnt==FALL_CYCLES−1: holes[pos]←0 (floor reached; column becomes solid) and fall_cnt←0.
  - `~aaah` → fall_cnt←0.
  - `aaah & ground` → no change.
- Only one of move/dig/fall can apply in a cycle, given walker one-hot outputs. If inputs are not one-hot, apply all enabled updates independently; pos follows the move rule.

## Timing
- Reset values: pos=0, holes=0, walls=0, counters=0. Hence ground=1, bump_left=1, bump_right=0, holes=0.
- Move latency: `pos` changes on the edge where the walker is in a walk state. This matches the walker's state update on the same edge.
- Dig: hole appears (`ground`=0) on the DIG_CYCLES-th consecutive grounded digging edge.
- Fall: `ground` returns 1 on the FALL_CYCLES-th consecutive airborne aaah edge.
- `areset` mid-dig or mid-fall aborts immediately; no partial terrain change persists.

## Structure
- Package `lemming_pkg`: parameter defaults (W, DIG_CYCLES, FALL_CYCLES) and the walker state encodings shared with the walker FSM.
- Sub-module `lemming_cycle_counter`:
  - Ports: enable, clear, terminal-count pulse.
  - Parameterized length.
  - Instantiated twice, for dig and fall.

## Test plan
(W=8, DIG_CYCLES=4, FALL_CYCLES=3)
- Reset → pos=0, ground=1, bump_left=1, bump_right=0, holes=0.
- load pos=3, walls=0, holes=0; walk_left 5 cycles → pos 2,1,0,0,0; bump_left=1 from pos=0.
- load pos=3, walls=8'h10; walk_right 3 cycles → pos 4,4,4; bump_right=1 at pos=4.
- load pos=2; digging 4 cycles → holes=8'h04 and ground=0 after 4th edge; then aaah 3 cycles → ground=1, holes=0 after 3rd edge.
- digging 2 cycles, idle 1, digging 3 cycles → holes unchanged (counter cleared); 4th consecutive cycle opens the hole.
- areset pulse after 2 aaah cycles over a hole → pos=0, holes=0, ground=1 immediately; load during walk → loaded values win that edge.
